// File: rtl/cache_types_pkg.sv
// Shared types for the cache line burst adaptor.
// Holds the adaptor FSM state type, the default line/beat word types and the
// default number of memory beats per line.
package cache_types_pkg;

  localparam int S_OFFSET = 5;
  localparam int S_BURST  = 64;
  localparam int S_LINE   = 8 * (2 ** S_OFFSET);
  localparam int BEATS    = S_LINE / S_BURST;

  typedef logic [S_LINE-1:0]  line_t;
  typedef logic [S_BURST-1:0] beat_t;

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    FILL_WR,
    WB,
    DONE
  } adaptor_state_t;

endpackage

// File: rtl/burst_beat_counter.sv
// Beat counter and slot generator for one memory burst.
// Ports:
//   clk, rst  - clock, async active-high reset
//   i_load    - start a new burst: count <= 0, start <= i_start
//   i_start   - first slot of the burst (critical beat)
//   i_adv     - one beat accepted, advance the count (wraps mod BEATS_P)
//   o_slot    - line slot of the current beat = (start + count) mod BEATS_P
//   o_last    - current beat is the final beat of the burst
module burst_beat_counter #(
  parameter int BEATS_P = 4,
  parameter int CW      = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_load,
  input  logic [CW-1:0] i_start,
  input  logic          i_adv,
  output logic [CW-1:0] o_slot,
  output logic          o_last
);

  logic [CW-1:0] r_count;
  logic [CW-1:0] r_start;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
      r_start <= '0;
    end else if (i_load) begin
      r_count <= '0;
      r_start <= i_start;
    end else if (i_adv) begin
      r_count <= o_last ? '0 : r_count + 1'b1;
    end
  end

  assign o_last = (r_count == CW'(BEATS_P - 1));
  // BEATS_P is a power of two, so CW-bit truncation of the sum is the modulo.
  assign o_slot = r_start + r_count;

endmodule

// File: rtl/cacheline_burst_adaptor.sv
// Converts L1 line transfers into fixed-length memory bursts.
// Fill: gathers BEATS inbound beats into a line, then writes it to the data
// array with a one-cycle full byte mask. Writeback: sends a latched dirty
// line out as BEATS beats.
// Build option: LINE_WRAP_EN selects critical-beat-first ordering, starting
// at the beat addressed by address_i and issuing the beat-aligned address.
// Ports:
//   read_i/write_i/address_i/line_i  - controller request (held until resp_o)
//   line_o/resp_o                    - assembled line, completion pulse
//   fill_write_en/windex/data        - data array write port
//   mem_*                            - memory burst interface
//
// state   | meaning
// IDLE    | waiting for a request; writeback has priority over fill
// FILL    | mem_read_o high, collecting inbound beats
// FILL_WR | one-cycle full-mask write of the assembled line to the array
// WB      | mem_write_o high, sending outbound beats
// DONE    | resp_o pulse, then back to IDLE
module cacheline_burst_adaptor
  import cache_types_pkg::*;
#(
  parameter  int s_offset = 5,
  parameter  int s_index  = 3,
  parameter  int s_burst  = 64,
  parameter  int s_addr   = 32,
  localparam int S_LINE   = 8 * (2 ** s_offset)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   read_i,
  input  logic                   write_i,
  input  logic [s_addr-1:0]      address_i,
  input  logic [S_LINE-1:0]      line_i,
  output logic [S_LINE-1:0]      line_o,
  output logic                   resp_o,
  output logic [2**s_offset-1:0] fill_write_en,
  output logic [s_index-1:0]     fill_windex,
  output logic [S_LINE-1:0]      fill_data,
  output logic                   mem_read_o,
  output logic                   mem_write_o,
  output logic [s_addr-1:0]      mem_address_o,
  output logic [s_burst-1:0]     mem_wdata_o,
  input  logic [s_burst-1:0]     mem_rdata_i,
  input  logic                   mem_resp_i
);

  localparam int BEATS_L = S_LINE / s_burst;
  localparam int CW      = (BEATS_L > 1) ? $clog2(BEATS_L) : 1;
`ifdef LINE_WRAP_EN
  localparam int LOW_BITS = $clog2(s_burst / 8);
`else
  localparam int LOW_BITS = s_offset;
`endif
  localparam logic [s_addr-1:0] ADDR_MASK = {s_addr{1'b1}} << LOW_BITS;

  adaptor_state_t    r_state, w_next;
  logic [s_addr-1:0] r_addr;
  logic [S_LINE-1:0] r_wline;
  logic [S_LINE-1:0] r_line;
  logic              w_load;
  logic              w_adv;
  logic [CW-1:0]     w_start;
  logic [CW-1:0]     w_slot;
  logic              w_last;

`ifdef LINE_WRAP_EN
  assign w_start = address_i[s_offset-1 -: CW];
`else
  assign w_start = '0;
`endif

  burst_beat_counter #(
    .BEATS_P (BEATS_L),
    .CW      (CW)
  ) u_cnt (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_load),
    .i_start (w_start),
    .i_adv   (w_adv),
    .o_slot  (w_slot),
    .o_last  (w_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_addr  <= '0;
      r_wline <= '0;
      r_line  <= '0;
    end else begin
      r_state <= w_next;
      if (w_load) r_addr <= address_i;
      if (r_state == IDLE && write_i) r_wline <= line_i;
      if (r_state == FILL && mem_resp_i) r_line[w_slot*s_burst +: s_burst] <= mem_rdata_i;
    end
  end

  always_comb begin
    w_next        = r_state;
    w_load        = 1'b0;
    w_adv         = 1'b0;
    resp_o        = 1'b0;
    fill_write_en = '0;
    fill_windex   = '0;
    mem_read_o    = 1'b0;
    mem_write_o   = 1'b0;
    mem_address_o = '0;
    mem_wdata_o   = '0;
    case (r_state)
      IDLE: begin
        if (write_i) begin
          w_next = WB;
          w_load = 1'b1;
        end else if (read_i) begin
          w_next = FILL;
          w_load = 1'b1;
        end
      end
      FILL: begin
        mem_read_o    = 1'b1;
        mem_address_o = r_addr & ADDR_MASK;
        if (mem_resp_i) begin
          w_adv = 1'b1;
          if (w_last) w_next = FILL_WR;
        end
      end
      FILL_WR: begin
        fill_write_en = '1;
        fill_windex   = r_addr[s_offset +: s_index];
        w_next        = DONE;
      end
      WB: begin
        mem_write_o   = 1'b1;
        mem_address_o = r_addr & ADDR_MASK;
        mem_wdata_o   = r_wline[w_slot*s_burst +: s_burst];
        if (mem_resp_i) begin
          w_adv = 1'b1;
          if (w_last) w_next = DONE;
        end
      end
      DONE: begin
        resp_o = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  assign line_o    = r_line;
  assign fill_data = r_line;

endmodule
